// File: rtl/prf_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prf_multiport                                                   |
// | Brief    : Physical register file with N read / M write / K allocation     |
// |            ports, a per-entry ready scoreboard, an optional hard-wired     |
// |            zero entry and a registered busy-entry counter.                 |
// | Options  : define PRF_MULTIPORT_BYPASS_EN for same-cycle write-to-read      |
// |            forwarding.                                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module prf_multiport #(
  parameter int PRF_SIZE = 64,
  parameter int DATA_W   = 32,
  parameter int RD_PORTS = 4,
  parameter int WR_PORTS = 2,
  parameter int AL_PORTS = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [RD_PORTS*$clog2(PRF_SIZE)-1:0] rd_idx,
  output logic [RD_PORTS*DATA_W-1:0]           rd_dat,
  output logic [RD_PORTS-1:0]                  rd_rdy,
  input  logic [WR_PORTS-1:0]                  wr_en,
  input  logic [WR_PORTS*$clog2(PRF_SIZE)-1:0] wr_idx,
  input  logic [WR_PORTS*DATA_W-1:0]           wr_dat,
  input  logic [AL_PORTS-1:0]                  al_en,
  input  logic [AL_PORTS*$clog2(PRF_SIZE)-1:0] al_idx,
  output logic [$clog2(PRF_SIZE):0]            busy_cnt
);

  localparam int c_IDX_W = $clog2(PRF_SIZE);

  logic [DATA_W-1:0]   r_rf [PRF_SIZE];
  logic [PRF_SIZE-1:0] r_ready;
  logic [c_IDX_W:0]    r_busy_cnt;

  logic [PRF_SIZE-1:0] w_ready_nxt;
  logic [c_IDX_W:0]    w_busy_nxt;

  logic [c_IDX_W-1:0]  w_wr_idx [WR_PORTS];
  logic [DATA_W-1:0]   w_wr_dat [WR_PORTS];
  logic [WR_PORTS-1:0] w_wr_act;
  logic [c_IDX_W-1:0]  w_al_idx [AL_PORTS];
  logic [AL_PORTS-1:0] w_al_act;

  // Requests aimed at the hard-wired zero entry are dropped here, once,
  // so the array, scoreboard and bypass never see them.
  generate
    for (genvar j = 0; j < WR_PORTS; j++) begin : g_wr
      assign w_wr_idx[j] = wr_idx[j*c_IDX_W +: c_IDX_W];
      assign w_wr_dat[j] = wr_dat[j*DATA_W +: DATA_W];
      assign w_wr_act[j] = wr_en[j] && !((ZERO_REG != 0) && (w_wr_idx[j] == '0));
    end
    for (genvar k = 0; k < AL_PORTS; k++) begin : g_al
      assign w_al_idx[k] = al_idx[k*c_IDX_W +: c_IDX_W];
      assign w_al_act[k] = al_en[k] && !((ZERO_REG != 0) && (w_al_idx[k] == '0));
    end
  endgenerate

  // Allocation is applied after writeback so it wins on the same entry.
  always_comb begin
    w_ready_nxt = r_ready;
    for (int j = 0; j < WR_PORTS; j++) begin
      if (w_wr_act[j]) w_ready_nxt[w_wr_idx[j]] = 1'b1;
    end
    for (int k = 0; k < AL_PORTS; k++) begin
      if (w_al_act[k]) w_ready_nxt[w_al_idx[k]] = 1'b0;
    end
  end

  always_comb begin
    w_busy_nxt = '0;
    for (int e = 0; e < PRF_SIZE; e++) begin
      w_busy_nxt = w_busy_nxt + {{c_IDX_W{1'b0}}, ~w_ready_nxt[e]};
    end
  end

  // Ascending port loop: the last non-blocking write (highest port) wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < PRF_SIZE; e++) r_rf[e] <= '0;
      r_ready    <= '1;
      r_busy_cnt <= '0;
    end else begin
      for (int j = 0; j < WR_PORTS; j++) begin
        if (w_wr_act[j]) r_rf[w_wr_idx[j]] <= w_wr_dat[j];
      end
      r_ready    <= w_ready_nxt;
      r_busy_cnt <= w_busy_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  generate
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
      logic [c_IDX_W-1:0] w_idx;
      logic [DATA_W-1:0]  w_dat;
      logic               w_rdy;

      assign w_idx = rd_idx[i*c_IDX_W +: c_IDX_W];

`ifdef PRF_MULTIPORT_BYPASS_EN
      logic w_hit;
      always_comb begin
        w_dat = r_rf[w_idx];
        w_rdy = r_ready[w_idx];
        w_hit = 1'b0;
        for (int j = 0; j < WR_PORTS; j++) begin
          if (w_wr_act[j] && (w_wr_idx[j] == w_idx)) begin
            w_dat = w_wr_dat[j];
            w_hit = 1'b1;
          end
        end
        if (w_hit) begin
          w_rdy = 1'b1;
          for (int k = 0; k < AL_PORTS; k++) begin
            if (w_al_act[k] && (w_al_idx[k] == w_idx)) w_rdy = 1'b0;
          end
        end
        if ((ZERO_REG != 0) && (w_idx == '0)) begin
          w_dat = '0;
          w_rdy = 1'b1;
        end
      end
`else
      always_comb begin
        w_dat = r_rf[w_idx];
        w_rdy = r_ready[w_idx];
        if ((ZERO_REG != 0) && (w_idx == '0)) begin
          w_dat = '0;
          w_rdy = 1'b1;
        end
      end
`endif

      assign rd_dat[i*DATA_W +: DATA_W] = w_dat;
      assign rd_rdy[i]                  = w_rdy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prf_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_prf_multiport                                                |
// | Brief    : Scoreboard bench for prf_multiport (ZERO_REG=0 and ZERO_REG=1). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_prf_multiport;

  localparam int c_SIZE = 64;
  localparam int c_DW   = 32;
  localparam int c_RD   = 4;
  localparam int c_WR   = 2;
  localparam int c_AL   = 2;
  localparam int c_IW   = 6;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [c_RD*c_IW-1:0] rd_idx, z_rd_idx;
  logic [c_RD*c_DW-1:0] rd_dat, z_rd_dat;
  logic [c_RD-1:0]      rd_rdy, z_rd_rdy;
  logic [c_WR-1:0]      wr_en, z_wr_en;
  logic [c_WR*c_IW-1:0] wr_idx, z_wr_idx;
  logic [c_WR*c_DW-1:0] wr_dat, z_wr_dat;
  logic [c_AL-1:0]      al_en, z_al_en;
  logic [c_AL*c_IW-1:0] al_idx, z_al_idx;
  logic [c_IW:0]        busy_cnt, z_busy_cnt;

  prf_multiport #(.PRF_SIZE(c_SIZE), .DATA_W(c_DW), .RD_PORTS(c_RD),
                  .WR_PORTS(c_WR), .AL_PORTS(c_AL), .ZERO_REG(0)) u_dut (
    .clock(clock), .reset(reset), .rd_idx(rd_idx), .rd_dat(rd_dat), .rd_rdy(rd_rdy),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_dat(wr_dat), .al_en(al_en), .al_idx(al_idx),
    .busy_cnt(busy_cnt));

  prf_multiport #(.PRF_SIZE(c_SIZE), .DATA_W(c_DW), .RD_PORTS(c_RD),
                  .WR_PORTS(c_WR), .AL_PORTS(c_AL), .ZERO_REG(1)) u_dut_zero (
    .clock(clock), .reset(reset), .rd_idx(z_rd_idx), .rd_dat(z_rd_dat), .rd_rdy(z_rd_rdy),
    .wr_en(z_wr_en), .wr_idx(z_wr_idx), .wr_dat(z_wr_dat), .al_en(z_al_en), .al_idx(z_al_idx),
    .busy_cnt(z_busy_cnt));

  int checks = 0;
  int errors = 0;

  logic [c_DW-1:0] m_rf  [c_SIZE];
  bit              m_rdy [c_SIZE];

  string           sb_tag  [$];
  int              sb_kind [$];
  logic [c_DW-1:0] sb_exp  [$];

  task automatic check_val(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // kinds 0-3 rd_dat, 4-7 rd_rdy, 8 busy_cnt; 9-17 the same for the zero instance
  function automatic logic [c_DW-1:0] observe(input int kind);
    if (kind < 4)  return rd_dat[kind*c_DW +: c_DW];
    if (kind < 8)  return {31'b0, rd_rdy[kind-4]};
    if (kind == 8) return {25'b0, busy_cnt};
    if (kind < 13) return z_rd_dat[(kind-9)*c_DW +: c_DW];
    if (kind < 17) return {31'b0, z_rd_rdy[kind-13]};
    return {25'b0, z_busy_cnt};
  endfunction

  task automatic push(input string tag, input int kind, input logic [c_DW-1:0] exp);
    sb_tag.push_back(tag);
    sb_kind.push_back(kind);
    sb_exp.push_back(exp);
  endtask

  task automatic set_rd(input int p, input int idx);
    rd_idx[p*c_IW +: c_IW] = idx[c_IW-1:0];
  endtask
  task automatic set_wr(input int p, input int idx, input logic [c_DW-1:0] dat);
    wr_en[p] = 1'b1; wr_idx[p*c_IW +: c_IW] = idx[c_IW-1:0]; wr_dat[p*c_DW +: c_DW] = dat;
  endtask
  task automatic set_al(input int p, input int idx);
    al_en[p] = 1'b1; al_idx[p*c_IW +: c_IW] = idx[c_IW-1:0];
  endtask
  task automatic z_set_rd(input int p, input int idx);
    z_rd_idx[p*c_IW +: c_IW] = idx[c_IW-1:0];
  endtask
  task automatic z_set_wr(input int p, input int idx, input logic [c_DW-1:0] dat);
    z_wr_en[p] = 1'b1; z_wr_idx[p*c_IW +: c_IW] = idx[c_IW-1:0]; z_wr_dat[p*c_DW +: c_DW] = dat;
  endtask
  task automatic z_set_al(input int p, input int idx);
    z_al_en[p] = 1'b1; z_al_idx[p*c_IW +: c_IW] = idx[c_IW-1:0];
  endtask

  task automatic model_reset();
    for (int e = 0; e < c_SIZE; e++) begin
      m_rf[e]  = '0;
      m_rdy[e] = 1'b1;
    end
  endtask

  function automatic int model_busy();
    int n = 0;
    for (int e = 0; e < c_SIZE; e++) if (!m_rdy[e]) n++;
    return n;
  endfunction

  task automatic predict(input int p, output logic [c_DW-1:0] d, output logic r);
    int idx;
    bit hit;
    idx = int'(rd_idx[p*c_IW +: c_IW]);
    d   = m_rf[idx];
    r   = m_rdy[idx];
    hit = 1'b0;
`ifdef PRF_MULTIPORT_BYPASS_EN
    for (int j = 0; j < c_WR; j++) begin
      if (wr_en[j] && int'(wr_idx[j*c_IW +: c_IW]) == idx) begin
        d = wr_dat[j*c_DW +: c_DW];
        hit = 1'b1;
      end
    end
    if (hit) begin
      r = 1'b1;
      for (int k = 0; k < c_AL; k++)
        if (al_en[k] && int'(al_idx[k*c_IW +: c_IW]) == idx) r = 1'b0;
    end
`endif
  endtask

  // Compare everything queued for this cycle, then clock the DUTs and the model.
  task automatic step();
    string t;
    int k;
    logic [c_DW-1:0] e;
    @(negedge clock);
    while (sb_tag.size() > 0) begin
      t = sb_tag.pop_front();
      k = sb_kind.pop_front();
      e = sb_exp.pop_front();
      check_val(t, observe(k), e);
    end
    @(posedge clock);
    for (int j = 0; j < c_WR; j++) begin
      if (wr_en[j]) begin
        m_rf[int'(wr_idx[j*c_IW +: c_IW])]  = wr_dat[j*c_DW +: c_DW];
        m_rdy[int'(wr_idx[j*c_IW +: c_IW])] = 1'b1;
      end
    end
    for (int k2 = 0; k2 < c_AL; k2++)
      if (al_en[k2]) m_rdy[int'(al_idx[k2*c_IW +: c_IW])] = 1'b0;
    #1;
    wr_en = '0; al_en = '0; z_wr_en = '0; z_al_en = '0;
  endtask

  task automatic do_cycle(input string tag);
    logic [c_DW-1:0] d;
    logic r;
    for (int p = 0; p < c_RD; p++) begin
      predict(p, d, r);
      push($sformatf("%s_dat%0d", tag, p), p, d);
      push($sformatf("%s_rdy%0d", tag, p), 4 + p, {31'b0, r});
    end
    push({tag, "_busy"}, 8, model_busy());
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_idx = '0; wr_en = '0; wr_idx = '0; wr_dat = '0; al_en = '0; al_idx = '0;
    z_rd_idx = '0; z_wr_en = '0; z_wr_idx = '0; z_wr_dat = '0; z_al_en = '0; z_al_idx = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    set_rd(0, 0); set_rd(1, 1); set_rd(2, 2); set_rd(3, 63);
    push("reset_busy", 8, 0);
    push("reset_zbusy", 17, 0);
    do_cycle("reset_state");

    set_rd(0, 12); set_al(0, 12);
    do_cycle("al12_c0");
    push("al12_rdy", 4, 0); push("al12_busy", 8, 1);
    do_cycle("al12_c1");
    set_wr(1, 12, 32'h1234);
    do_cycle("wb12_c2");
    push("wb12_dat", 0, 32'h1234); push("wb12_rdy", 4, 1); push("wb12_busy", 8, 0);
    do_cycle("wb12_c3");

    set_rd(1, 7); set_wr(0, 7, 32'hAAAA); set_wr(1, 7, 32'h5555);
    do_cycle("conf_c0");
    push("conf_dat", 1, 32'h5555);
    do_cycle("conf_c1");

    set_rd(2, 9); set_al(1, 9); set_wr(0, 9, 32'h77);
    do_cycle("avw_c0");
    push("avw_rdy", 6, 0); push("avw_dat", 2, 32'h77); push("avw_busy", 8, 1);
    do_cycle("avw_c1");

    set_wr(0, 3, 32'h1111);
    do_cycle("byp_pre");
    set_rd(3, 3); set_wr(0, 3, 32'hBEEF);
`ifdef PRF_MULTIPORT_BYPASS_EN
    push("byp_dat", 3, 32'hBEEF); push("byp_rdy", 7, 1);
`else
    push("byp_dat", 3, 32'h1111);
`endif
    do_cycle("byp_c0");
    push("byp_next_dat", 3, 32'hBEEF); push("byp_next_rdy", 7, 1);
    do_cycle("byp_c1");

    set_al(0, 20); set_al(1, 20);
    do_cycle("dup_c0");
    push("dup_busy", 8, 2);
    do_cycle("dup_c1");

    for (int c = 0; c < 32; c++) begin
      set_rd(0, 2*c); set_al(0, 2*c); set_al(1, 2*c + 1);
      do_cycle("fill");
    end
    push("full_busy", 8, 64);
    do_cycle("full");
    for (int c = 0; c < 32; c++) begin
      set_wr(0, 2*c, 32'(c)); set_wr(1, 2*c + 1, ~32'(c));
      do_cycle("release");
    end
    push("empty_busy", 8, 0);
    do_cycle("empty");

    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < c_RD; p++) set_rd(p, $urandom_range(15, 0));
      for (int j = 0; j < c_WR; j++)
        if ($urandom_range(1, 0) == 1) set_wr(j, $urandom_range(15, 0), $urandom());
      for (int k = 0; k < c_AL; k++)
        if ($urandom_range(2, 0) == 0) set_al(k, $urandom_range(15, 0));
      do_cycle("rnd");
    end

    set_wr(0, 5, 32'hDEAD); set_al(0, 30);
    do_cycle("pre_rst");
    for (int p = 0; p < c_RD; p++) set_rd(p, 5);
    set_rd(3, 30);
    #1;
    check_val("pre_rst_dat", rd_dat[31:0], 32'hDEAD);
    check_val("pre_rst_rdy30", {31'b0, rd_rdy[3]}, 32'h0);
    #1 reset = 1'b1;
    #1;
    for (int p = 0; p < c_RD; p++) begin
      check_val($sformatf("async_rst_dat%0d", p), rd_dat[p*c_DW +: c_DW], 32'h0);
      check_val($sformatf("async_rst_rdy%0d", p), {31'b0, rd_rdy[p]}, 32'h1);
    end
    check_val("async_rst_busy", {25'b0, busy_cnt}, 32'h0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    do_cycle("post_rst");

    z_set_rd(0, 0); z_set_rd(1, 5);
    z_set_wr(0, 0, 32'hFFFF); z_set_al(0, 0);
    push("z0_same_dat", 9, 0); push("z0_same_rdy", 13, 1);
    step();
    push("z0_dat", 9, 0); push("z0_rdy", 13, 1); push("z0_busy", 17, 0);
    step();
    for (int c = 0; c < 32; c++) begin
      z_set_al(0, 2*c + 1); z_set_al(1, (2*c + 2) % 64);
      step();
    end
    push("zfull_busy", 17, 63); push("zfull_rdy5", 14, 0);
    push("zfull_dat0", 9, 0); push("zfull_rdy0", 13, 1);
    z_set_wr(1, 5, 32'hABCD);
    step();
    push("zwb_dat5", 10, 32'hABCD); push("zwb_rdy5", 14, 1); push("zwb_busy", 17, 62);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
